// File: rtl/ref_ramp_ctrl.sv
// Setpoint ramp controller: debounced up/down buttons with hold-to-repeat stepping a 4-digit BCD
// setpoint, plus a shadow copy that only updates at PWM period boundaries.
module ref_ramp_ctrl #(
  parameter int unsigned DEB_MS   = 20,
  parameter int unsigned HOLD_MS  = 500,
  parameter int unsigned REP_MS   = 100,
  parameter int unsigned FAST_MS  = 10,
  parameter int unsigned FAST_CNT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce1ms,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        period_end,
  output logic [15:0] ref_bcd,
  output logic [15:0] ref_act,
  output logic        up,
  output logic        at_lim,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StDeb, StHold, StRepeat} state_e;

  state_e      state_q, state_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [7:0]  rep_cnt_q, rep_cnt_d;
  logic        dir_q, dir_d;
  logic [15:0] ref_bcd_q, ref_bcd_d;
  logic [15:0] ref_act_q, ref_act_d;
  logic        up_q, up_d;
  logic        u_meta_q, u, d_meta_q, d;
  logic        held, other, step, sat;
  logic [15:0] lim;

  // Digit-serial BCD +1/-1 with carry/borrow; limits are handled by the caller.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic inc);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (inc) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    lim = 16'(DEB_MS - 1);
    case (state_q)
      StHold:   lim = 16'(HOLD_MS - 1);
      StRepeat: lim = (rep_cnt_q < 8'(FAST_CNT)) ? 16'(REP_MS - 1) : 16'(FAST_MS - 1);
      default:  lim = 16'(DEB_MS - 1);
    endcase
  end

  assign held = dir_q ? u : d;
  assign other = dir_q ? d : u;

  always_comb begin
    state_d   = state_q;
    ms_cnt_d  = ms_cnt_q;
    rep_cnt_d = rep_cnt_q;
    dir_d     = dir_q;
    step      = 1'b0;
    if (state_q == StIdle) begin
      if (u ^ d) begin
        dir_d    = u;
        ms_cnt_d = '0;
        state_d  = StDeb;
      end
    end else if (!held || other) begin
      // Release or conflicting press beats a coincident tick.
      state_d = StIdle;
    end else if (ce1ms) begin
      if (ms_cnt_q == lim) begin
        step     = 1'b1;
        ms_cnt_d = '0;
        case (state_q)
          StDeb:  state_d = StHold;
          StHold: begin
            state_d   = StRepeat;
            rep_cnt_d = '0;
          end
          default: begin
            if (rep_cnt_q < 8'(FAST_CNT)) rep_cnt_d = rep_cnt_q + 8'd1;
          end
        endcase
      end else begin
        ms_cnt_d = ms_cnt_q + 16'd1;
      end
    end
  end

  assign sat = dir_q ? (ref_bcd_q == 16'h9999) : (ref_bcd_q == 16'h0000);

  always_comb begin
    ref_bcd_d = ref_bcd_q;
    up_d      = up_q;
    if (step) begin
      up_d = dir_q;
      if (!sat) ref_bcd_d = bcd_step(ref_bcd_q, dir_q);
    end
    // Shadow takes the pre-step value when a step lands on a period boundary.
    ref_act_d = period_end ? ref_bcd_q : ref_act_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u_meta_q  <= 1'b0;
      u         <= 1'b0;
      d_meta_q  <= 1'b0;
      d         <= 1'b0;
      state_q   <= StIdle;
      ms_cnt_q  <= '0;
      rep_cnt_q <= '0;
      dir_q     <= 1'b0;
      ref_bcd_q <= '0;
      ref_act_q <= '0;
      up_q      <= 1'b0;
    end else begin
      u_meta_q  <= btn_up;
      u         <= u_meta_q;
      d_meta_q  <= btn_dn;
      d         <= d_meta_q;
      state_q   <= state_d;
      ms_cnt_q  <= ms_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      dir_q     <= dir_d;
      ref_bcd_q <= ref_bcd_d;
      ref_act_q <= ref_act_d;
      up_q      <= up_d;
    end
  end

  assign ref_bcd = ref_bcd_q;
  assign ref_act = ref_act_q;
  assign up      = up_q;
  assign at_lim  = (ref_bcd_q == 16'h0000) || (ref_bcd_q == 16'h9999);
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_ref_ramp_ctrl.sv
// Scoreboard bench for ref_ramp_ctrl: expected steps are queued by the stimulus and popped by a
// monitor whenever ref_bcd changes; a second fast-parameter instance covers the 9999 limit.
module tb_ref_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, ce1ms, btn_up, btn_dn, period_end, btn2;
  logic [15:0] ref_bcd, ref_act, ref_bcd2, ref_act2;
  logic        up, at_lim, busy, up2, at_lim2, busy2;

  always #5 clk = ~clk;

  ref_ramp_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce1ms      (ce1ms),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .period_end (period_end),
    .ref_bcd    (ref_bcd),
    .ref_act    (ref_act),
    .up         (up),
    .at_lim     (at_lim),
    .busy       (busy)
  );

  ref_ramp_ctrl #(
    .DEB_MS   (2),
    .HOLD_MS  (2),
    .REP_MS   (2),
    .FAST_MS  (1),
    .FAST_CNT (1)
  ) u_dut_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce1ms      (1'b1),
    .btn_up     (btn2),
    .btn_dn     (1'b0),
    .period_end (1'b0),
    .ref_bcd    (ref_bcd2),
    .ref_act    (ref_act2),
    .up         (up2),
    .at_lim     (at_lim2),
    .busy       (busy2)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        dir;
    int          gap;  // expected ce1ms ticks since previous change; 0 = not checked
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tick_no = 0;
  int          bad2 = 0;
  logic        mon_en = 1'b0;

  // 1 ms tick every other clock, changing on the falling edge.
  initial begin
    ce1ms = 1'b0;
    forever begin
      @(negedge clk);
      ce1ms = !ce1ms;
    end
  end

  always @(posedge clk) if (ce1ms) tick_no <= tick_no + 1;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] bcd, input logic dir, input int gap);
    exp_t e;
    e.bcd = bcd;
    e.dir = dir;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Expected steps of one continuous hold: DEB step, HOLD step, 10 slow repeats, then fast.
  task automatic push_hold(input int start, input int nsteps, input logic dir);
    int g;
    for (int k = 0; k < nsteps; k++) begin
      g = (k == 0) ? 0 : (k == 1) ? 500 : (k <= 11) ? 100 : 10;
      push(to_bcd(dir ? start + k + 1 : start - k - 1), dir, g);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (ce1ms) k++;
    end
    @(negedge clk);
  endtask

  task automatic wait_bcd(input string name, input logic [15:0] target, input int max_ticks);
    int n = 0;
    while (ref_bcd !== target && n < 2 * max_ticks + 20) begin
      @(negedge clk);
      n++;
    end
    check(name, ref_bcd, target);
  endtask

  // Monitor: every change of ref_bcd must match the next queued expectation.
  initial begin
    logic [15:0] last_bcd;
    int          last_tick;
    exp_t        e;
    wait (mon_en);
    last_bcd  = 16'h0000;
    last_tick = tick_no;
    forever begin
      @(negedge clk);
      if (ref_bcd !== last_bcd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: got %0h, expected no change from %0h", ref_bcd, last_bcd);
        end else begin
          e = exp_q.pop_front();
          check("step_bcd", ref_bcd, e.bcd);
          check("step_up", up, e.dir);
          if (e.gap != 0) check("step_gap", tick_no - last_tick, e.gap);
        end
        last_bcd  = ref_bcd;
        last_tick = tick_no;
      end
    end
  end

  // Fast instance only ever counts up: each change must be exactly +1 in BCD.
  initial begin
    logic [15:0] prev2;
    wait (mon_en);
    prev2 = 16'h0000;
    forever begin
      @(negedge clk);
      if (ref_bcd2 !== prev2) begin
        if (ref_bcd2 !== to_bcd(from_bcd(prev2) + 1)) bad2++;
        prev2 = ref_bcd2;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; period_end = 1'b0; btn2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bcd", ref_bcd, 16'h0000);
    check("rst_act", ref_act, 16'h0000);
    check("rst_up", up, 1'b0);
    check("rst_at_lim", at_lim, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single press held 25 ticks: exactly one step, shadow waits for period_end.
    push(16'h0001, 1'b1, 0);
    btn_up = 1'b1;
    wait_ticks(25);
    btn_up = 1'b0;
    wait_ticks(3);
    check("press_busy", busy, 1'b0);
    check("press_bcd", ref_bcd, 16'h0001);
    check("press_at_lim", at_lim, 1'b0);
    check("press_act_hold", ref_act, 16'h0000);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
    check("press_act_load", ref_act, 16'h0001);

    // 15-tick glitch: no step, back to idle.
    btn_up = 1'b1;
    wait_ticks(15);
    check("glitch_busy_on", busy, 1'b1);
    btn_up = 1'b0;
    wait_ticks(3);
    check("glitch_busy_off", busy, 1'b0);
    check("glitch_bcd", ref_bcd, 16'h0001);

    // Continuous hold from 0000: 20, +500, 10 x 100, then every 10 ticks.
    push(16'h0000, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_hold(0, 14, 1'b1);
    btn_up = 1'b1;
    wait_bcd("hold_reach_12", 16'h0012, 1700);
    wait_bcd("hold_reach_14", 16'h0014, 100);
    btn_up = 1'b0;
    wait_ticks(3);

    // Both buttons, and a conflicting press during a hold: no step.
    btn_up = 1'b1;
    btn_dn = 1'b1;
    wait_ticks(30);
    check("both_busy", busy, 1'b0);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_ticks(3);
    btn_up = 1'b1;
    wait_ticks(5);
    check("conflict_busy_on", busy, 1'b1);
    btn_dn = 1'b1;
    wait_ticks(30);
    check("conflict_busy_off", busy, 1'b0);
    check("conflict_bcd", ref_bcd, 16'h0014);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_ticks(3);

    // Ramp up to 0100, then one down step for the borrow 0100 -> 0099.
    push_hold(14, 86, 1'b1);
    btn_up = 1'b1;
    wait_bcd("ramp_reach_100", 16'h0100, 3000);
    btn_up = 1'b0;
    wait_ticks(3);
    push(16'h0099, 1'b0, 0);
    btn_dn = 1'b1;
    wait_ticks(25);
    btn_dn = 1'b0;
    wait_ticks(3);
    check("borrow_bcd", ref_bcd, 16'h0099);
    check("borrow_up", up, 1'b0);

    // Step coincident with period_end: shadow takes the pre-step value.
    period_end = 1'b1;
    push(16'h0100, 1'b1, 0);
    btn_up = 1'b1;
    n = 0;
    while (ref_bcd === 16'h0099 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("coinc_bcd", ref_bcd, 16'h0100);
    check("coinc_act_old", ref_act, 16'h0099);
    @(negedge clk);
    check("coinc_act_new", ref_act, 16'h0100);
    period_end = 1'b0;
    btn_up = 1'b0;
    wait_ticks(3);

    // Reset during REPEAT, then a still-held button restarts debounce.
    push_hold(100, 2, 1'b1);
    btn_up = 1'b1;
    wait_bcd("rep_reach_102", 16'h0102, 600);
    wait_ticks(10);
    check("rep_busy", busy, 1'b1);
    push(16'h0000, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bcd", ref_bcd, 16'h0000);
    check("midrst_act", ref_act, 16'h0000);
    check("midrst_up", up, 1'b0);
    check("midrst_at_lim", at_lim, 1'b1);
    check("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    push(16'h0001, 1'b1, 0);
    wait_ticks(15);
    check("redeb_no_step", ref_bcd, 16'h0000);
    check("redeb_busy", busy, 1'b1);
    wait_bcd("redeb_step", 16'h0001, 20);
    btn_up = 1'b0;
    wait_ticks(3);

    // Down to 0000, then a further down press saturates.
    push(16'h0000, 1'b0, 0);
    btn_dn = 1'b1;
    wait_ticks(25);
    btn_dn = 1'b0;
    wait_ticks(3);
    btn_dn = 1'b1;
    wait_ticks(25);
    btn_dn = 1'b0;
    wait_ticks(3);
    check("low_sat_bcd", ref_bcd, 16'h0000);
    check("low_sat_up", up, 1'b0);
    check("low_sat_at_lim", at_lim, 1'b1);

    // Fast instance: hold up through 9998 to 9999, then keep repeating at the limit.
    btn2 = 1'b1;
    n = 0;
    while (ref_bcd2 !== 16'h9999 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check("fast_reach_9999", ref_bcd2, 16'h9999);
    check("fast_at_lim", at_lim2, 1'b1);
    repeat (50) @(negedge clk);
    check("fast_sat_bcd", ref_bcd2, 16'h9999);
    check("fast_sat_up", up2, 1'b1);
    check("fast_sat_busy", busy2, 1'b1);
    check("fast_seq_errors", bad2, 0);
    btn2 = 1'b0;
    repeat (5) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
